// File: rtl/pcm_frame_sched_pkg.sv
// Shared types and constants for the PCM frame scheduler.
package pcm_frame_sched_pkg;

  localparam int unsigned DEF_N_CHAN  = 12;
  localparam int unsigned DEF_FRAMES  = 32;
  localparam int unsigned DEF_HDR_LEN = 14;
  localparam int unsigned DEF_ADDR_W  = 11;

  typedef enum logic [2:0] {
    IDLE,
    WR_LO,
    WR_HI,
    CHECK,
    START
  } sched_state_e;

  function automatic int unsigned payload_bytes(input int unsigned n_chan,
                                                input int unsigned frames);
    return 2 * n_chan * frames;
  endfunction

  function automatic int unsigned bank_size(input int unsigned addr_w);
    return 1 << (addr_w - 1);
  endfunction

  localparam int unsigned PAYLOAD_BYTES = payload_bytes(DEF_N_CHAN, DEF_FRAMES);
  localparam int unsigned BANK_SIZE     = bank_size(DEF_ADDR_W);

endpackage

// File: rtl/pcm_frame_sched_if.sv
// BRAM write port and transmitter handshake of the PCM frame scheduler.
interface pcm_frame_sched_if #(
  parameter int unsigned ADDR_W = 11
);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              tx_start;
  logic              tx_bank;
  logic              tx_busy;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    output tx_start,
    output tx_bank,
    input  tx_busy
  );

  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  tx_start,
    input  tx_bank,
    output tx_busy
  );

endinterface

// File: rtl/pcm_frame_sched_sat_counter16.sv
// 16-bit event counter with synchronous clear that sticks at 0xFFFF.
module sat_counter16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  output logic [15:0] cnt
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Next count: clear wins, otherwise increment unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pcm_frame_sched.sv
// PCM packet scheduler: snapshots channel samples on each strobe, writes them
// as little-endian bytes into a ping-pong BRAM bank and hands full banks to
// the Ethernet transmitter.
module pcm_frame_sched
  import pcm_frame_sched_pkg::*;
#(
  parameter int unsigned N_CHAN  = DEF_N_CHAN,
  parameter int unsigned FRAMES  = DEF_FRAMES,
  parameter int unsigned HDR_LEN = DEF_HDR_LEN,
  parameter int unsigned ADDR_W  = DEF_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pcm_stb,
  input  logic [16*N_CHAN-1:0]  pcm_flat,
  pcm_frame_sched_if.master     bus,
  output logic [15:0]           miss_cnt,
  output logic [15:0]           drop_cnt
);

  localparam int unsigned CHAN_W     = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
  localparam int unsigned FRAME_W    = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int unsigned BANK_BYTES = bank_size(ADDR_W);

  localparam logic [CHAN_W-1:0]  LAST_CHAN  = CHAN_W'(N_CHAN - 1);
  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(FRAMES - 1);

  // First payload byte address of a bank.
  function automatic logic [ADDR_W-1:0] bank_base(input logic b);
    return b ? ADDR_W'(BANK_BYTES + HDR_LEN) : ADDR_W'(HDR_LEN);
  endfunction

  sched_state_e                   state_q,   state_d;
  logic [CHAN_W-1:0]              chan_q,    chan_d;
  logic [FRAME_W-1:0]             frame_q,   frame_d;
  logic                           bank_q,    bank_d;
  logic                           tx_bank_q, tx_bank_d;
  logic [ADDR_W-1:0]              ptr_q,     ptr_d;
  logic [N_CHAN-1:0][15:0]        shadow_q,  shadow_d;
  logic                           wr_en_q,   wr_en_d;
  logic [ADDR_W-1:0]              wr_addr_q, wr_addr_d;
  logic [7:0]                     wr_data_q, wr_data_d;

  logic tx_start;
  logic miss_inc;
  logic drop_inc;

  // FSM next state, byte pointer and write-port values.
  // Write outputs are loaded from the transition into WR_LO/WR_HI rather than
  // decoded from the current state, so byte k lands k+1 cycles after the strobe.
  always_comb begin
    state_d   = state_q;
    chan_d    = chan_q;
    frame_d   = frame_q;
    bank_d    = bank_q;
    tx_bank_d = tx_bank_q;
    ptr_d     = ptr_q;
    shadow_d  = shadow_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    tx_start  = 1'b0;
    drop_inc  = 1'b0;
    miss_inc  = pcm_stb && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (pcm_stb) begin
          shadow_d  = pcm_flat;
          chan_d    = '0;
          state_d   = WR_LO;
          wr_en_d   = 1'b1;
          wr_addr_d = ptr_q;
          wr_data_d = pcm_flat[7:0];
          ptr_d     = ptr_q + 1'b1;
        end
      end
      WR_LO: begin
        state_d   = WR_HI;
        wr_en_d   = 1'b1;
        wr_addr_d = ptr_q;
        wr_data_d = shadow_q[chan_q][15:8];
        ptr_d     = ptr_q + 1'b1;
      end
      WR_HI: begin
        if (chan_q == LAST_CHAN) begin
          state_d = CHECK;
        end else begin
          chan_d    = chan_q + 1'b1;
          state_d   = WR_LO;
          wr_en_d   = 1'b1;
          wr_addr_d = ptr_q;
          wr_data_d = shadow_q[chan_d][7:0];
          ptr_d     = ptr_q + 1'b1;
        end
      end
      CHECK: begin
        if (frame_q != LAST_FRAME) begin
          frame_d = frame_q + 1'b1;
          state_d = IDLE;
        end else begin
          state_d = START;
        end
      end
      START: begin
        frame_d = '0;
        state_d = IDLE;
        if (!bus.tx_busy) begin
          tx_start  = 1'b1;
          tx_bank_d = bank_q;
          bank_d    = ~bank_q;
          ptr_d     = bank_base(~bank_q);
        end else begin
          drop_inc = 1'b1;
          ptr_d    = bank_base(bank_q);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, pointer, snapshot and registered write-port flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      chan_q    <= '0;
      frame_q   <= '0;
      bank_q    <= 1'b0;
      tx_bank_q <= 1'b1;
      ptr_q     <= bank_base(1'b0);
      shadow_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      chan_q    <= chan_d;
      frame_q   <= frame_d;
      bank_q    <= bank_d;
      tx_bank_q <= tx_bank_d;
      ptr_q     <= ptr_d;
      shadow_q  <= shadow_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.tx_start = tx_start;
  // The bank being started is visible in the same cycle as the start pulse.
  assign bus.tx_bank  = tx_start ? bank_q : tx_bank_q;

  sat_counter16 u_miss_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .en  (miss_inc),
    .cnt (miss_cnt)
  );

  sat_counter16 u_drop_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .en  (drop_inc),
    .cnt (drop_cnt)
  );

endmodule

// File: tb/tb_pcm_frame_sched.sv
// Directed scoreboard bench for pcm_frame_sched.
module tb_pcm_frame_sched;
  import pcm_frame_sched_pkg::*;

  localparam int unsigned NC = 12;
  localparam int unsigned FR = 32;
  localparam int unsigned HL = 14;
  localparam int unsigned AW = 11;
  localparam int unsigned SET_BYTES = PAYLOAD_BYTES / FR;

  logic                clk = 1'b0;
  logic                rst;
  logic                pcm_stb;
  logic [16*NC-1:0]    pcm_flat;
  logic [15:0]         miss_cnt;
  logic [15:0]         drop_cnt;

  pcm_frame_sched_if #(.ADDR_W(AW)) bus ();

  pcm_frame_sched #(
    .N_CHAN  (NC),
    .FRAMES  (FR),
    .HDR_LEN (HL),
    .ADDR_W  (AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pcm_stb  (pcm_stb),
    .pcm_flat (pcm_flat),
    .bus      (bus),
    .miss_cnt (miss_cnt),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned addr;
    int unsigned data;
    int unsigned cyc;
  } wr_exp_t;

  typedef struct {
    int unsigned bank;
    int unsigned cyc;
  } tx_exp_t;

  wr_exp_t     wq[$];
  tx_exp_t     txq[$];
  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;
  logic        mon_on = 1'b1;
  int unsigned mbank, mframe;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: compare every write and every start pulse on the falling edge.
  always @(negedge clk) begin
    if (mon_on) begin
      if (bus.wr_en === 1'b1) begin
        check("wr_expected", 32'(wq.size() > 0), 32'd1);
        if (wq.size() > 0) begin
          wr_exp_t e;
          e = wq.pop_front();
          check("wr_addr", 32'(bus.wr_addr), e.addr);
          check("wr_data", 32'(bus.wr_data), e.data);
          check("wr_cycle", cyc, e.cyc);
        end
      end
      if (bus.tx_start === 1'b1) begin
        check("tx_expected", 32'(txq.size() > 0), 32'd1);
        if (txq.size() > 0) begin
          tx_exp_t t;
          t = txq.pop_front();
          check("tx_bank_at_start", 32'(bus.tx_bank), t.bank);
          check("tx_cycle", cyc, t.cyc);
        end
      end
    end
  end

  function automatic logic [16*NC-1:0] rand_set();
    logic [16*NC-1:0] d;
    for (int c = 0; c < NC; c++) d[16*c +: 16] = 16'($urandom);
    return d;
  endfunction

  task automatic push_set(input logic [16*NC-1:0] d, input int unsigned n_bytes,
                          input int unsigned c0);
    wr_exp_t e;
    for (int unsigned k = 0; k < n_bytes; k++) begin
      e.addr = mbank * BANK_SIZE + HL + SET_BYTES * mframe + k;
      e.data = 32'(d[8*k +: 8]);
      e.cyc  = c0 + 1 + k;
      wq.push_back(e);
    end
  endtask

  task automatic end_of_set();
    tx_exp_t t;
    if (mframe == FR - 1) begin
      if (bus.tx_busy == 1'b0) begin
        t.bank = mbank;
        t.cyc  = cyc + 2;
        txq.push_back(t);
        mbank ^= 1;
      end
      mframe = 0;
    end else begin
      mframe++;
    end
  endtask

  // One full sample set, 40 cycles from strobe to next possible strobe.
  task automatic run_set(input logic [16*NC-1:0] d);
    int unsigned c0;
    c0 = cyc;
    push_set(d, SET_BYTES, c0);
    pcm_flat = d;
    pcm_stb  = 1'b1;
    tick();
    pcm_stb  = 1'b0;
    repeat (SET_BYTES - 1) tick();
    end_of_set();
    repeat (40 - SET_BYTES) tick();
  endtask

  initial begin
    logic [16*NC-1:0] d;
    int unsigned      c0;

    rst          = 1'b1;
    pcm_stb      = 1'b0;
    pcm_flat     = '0;
    bus.tx_busy  = 1'b0;
    mbank        = 0;
    mframe       = 0;
    repeat (3) tick();
    check("rst_wr_en", 32'(bus.wr_en), 32'd0);
    check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    check("rst_wr_data", 32'(bus.wr_data), 32'd0);
    check("rst_tx_start", 32'(bus.tx_start), 32'd0);
    check("rst_tx_bank", 32'(bus.tx_bank), 32'd1);
    check("rst_miss", 32'(miss_cnt), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // First packet: known pattern then random sets, transmitter idle.
    for (int c = 0; c < NC; c++) d[16*c +: 16] = 16'h1100 + 16'(c);
    run_set(d);
    for (int s = 1; s < FR; s++) run_set(rand_set());
    check("pkt1_tx_q_empty", 32'(txq.size()), 32'd0);
    check("pkt1_tx_bank", 32'(bus.tx_bank), 32'd0);

    // Second packet completes while transmitter still busy.
    run_set(rand_set());
    bus.tx_busy = 1'b1;
    for (int s = 1; s < FR; s++) run_set(rand_set());
    check("drop_one", 32'(drop_cnt), 32'd1);
    check("drop_tx_bank", 32'(bus.tx_bank), 32'd0);
    bus.tx_busy = 1'b0;

    // Strobe while busy writing: ignored, snapshot undisturbed.
    c0 = cyc;
    d  = rand_set();
    push_set(d, SET_BYTES, c0);
    pcm_flat = d;
    pcm_stb  = 1'b1;
    tick();
    pcm_stb  = 1'b0;
    repeat (4) tick();
    pcm_flat = ~d;
    pcm_stb  = 1'b1;
    tick();
    pcm_stb  = 1'b0;
    repeat (SET_BYTES - 6) tick();
    end_of_set();
    repeat (40 - SET_BYTES) tick();
    check("miss_one", 32'(miss_cnt), 32'd1);

    // Sets 1..6, then reset in the middle of set 7.
    for (int s = 1; s < 7; s++) run_set(rand_set());
    check("pre_rst_frame", mframe, 32'd7);
    c0 = cyc;
    d  = rand_set();
    push_set(d, 4, c0);
    pcm_flat = d;
    pcm_stb  = 1'b1;
    tick();
    pcm_stb  = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_wr_en", 32'(bus.wr_en), 32'd0);
    check("midrst_tx_bank", 32'(bus.tx_bank), 32'd1);
    check("midrst_miss", 32'(miss_cnt), 32'd0);
    check("midrst_drop", 32'(drop_cnt), 32'd0);
    check("midrst_wq_empty", 32'(wq.size()), 32'd0);
    mbank  = 0;
    mframe = 0;
    repeat (5) tick();
    run_set(rand_set());
    check("post_rst_wq_empty", 32'(wq.size()), 32'd0);
    check("post_rst_txq_empty", 32'(txq.size()), 32'd0);

    // Saturation: strobe held high, nearly every cycle is an ignored strobe.
    mon_on  = 1'b0;
    pcm_stb = 1'b1;
    repeat (72000) tick();
    check("miss_sat", 32'(miss_cnt), 32'hFFFF);
    repeat (100) tick();
    check("miss_sat_hold", 32'(miss_cnt), 32'hFFFF);
    check("sat_drop", 32'(drop_cnt), 32'd0);
    pcm_stb = 1'b0;
    repeat (40) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
